// File: rtl/qpu_exu_alu_wbq.sv
// In-order result queue between the ALU sub-units and the commit/write-back ports.
// The head retires only when commit and every write-back channel it needs are ready together.
module qpu_exu_alu_wbq #(
  parameter int XLEN    = 32,
  parameter int TIME_W  = 32,
  parameter int EVT_W   = 16,
  parameter int EVT_NUM = 4,
  parameter int RFIDX_W = 6,
  parameter int PC_W    = 32,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic [PC_W-1:0]          i_pc,
  input  logic [XLEN-1:0]          i_imm,
  input  logic                     i_bjp,
  input  logic                     i_bjp_prdt,
  input  logic                     i_bjp_rslv,
  input  logic                     i_qiu,
  input  logic                     i_ntp,
  input  logic                     i_rdwen,
  input  logic [RFIDX_W-1:0]       i_rdidx,
  input  logic [XLEN-1:0]          i_cdata,
  input  logic [TIME_W-1:0]        i_tdata,
  input  logic [EVT_W-1:0]         i_edata,
  input  logic [EVT_NUM-1:0]       i_oprand,
  output logic                     cmt_o_valid,
  input  logic                     cmt_o_ready,
  output logic [PC_W-1:0]          cmt_o_pc,
  output logic [XLEN-1:0]          cmt_o_imm,
  output logic                     cmt_o_bjp,
  output logic                     cmt_o_bjp_prdt,
  output logic                     cmt_o_bjp_rslv,
  output logic                     cwbck_o_valid,
  input  logic                     cwbck_o_ready,
  output logic [XLEN-1:0]          cwbck_o_data,
  output logic [RFIDX_W-1:0]       cwbck_o_rdidx,
  output logic                     qcwbck_o_valid,
  input  logic                     qcwbck_o_ready,
  output logic [XLEN-1:0]          qcwbck_o_data,
  output logic [RFIDX_W-1:0]       qcwbck_o_rdidx,
  output logic                     twbck_o_valid,
  input  logic                     twbck_o_ready,
  output logic [TIME_W-1:0]        twbck_o_data,
  output logic                     ewbck_o_valid,
  input  logic                     ewbck_o_ready,
  output logic [EVT_W-1:0]         ewbck_o_data,
  output logic [EVT_NUM-1:0]       ewbck_o_oprand,
  output logic [$clog2(DEPTH):0]   o_occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW-1:0] widx, hidx;
  logic          empty, full, push, pop, head_vld;
  logic [3:0]    need_in, hneed;
  logic          rdy_c, rdy_qc, rdy_t, rdy_e;

  logic [PC_W-1:0]    pc_q     [DEPTH];
  logic [XLEN-1:0]    imm_q    [DEPTH];
  logic               bjp_q    [DEPTH];
  logic               prdt_q   [DEPTH];
  logic               rslv_q   [DEPTH];
  logic [RFIDX_W-1:0] rdidx_q  [DEPTH];
  logic [XLEN-1:0]    cdata_q  [DEPTH];
  logic [TIME_W-1:0]  tdata_q  [DEPTH];
  logic [EVT_W-1:0]   edata_q  [DEPTH];
  logic [EVT_NUM-1:0] oprand_q [DEPTH];
  logic [3:0]         need_q   [DEPTH];

  assign widx  = wptr_q[AW-1:0];
  assign hidx  = rptr_q[AW-1:0];
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (widx == hidx);

  assign i_ready = ~full & ~flush;
  assign push    = i_valid & i_ready;

  // need mask bits: [0] classical, [1] quantum-classical, [2] time, [3] event
  assign need_in = {i_qiu | i_ntp,
                    i_ntp,
                    i_rdwen & i_rdidx[RFIDX_W-1],
                    i_rdwen & ~i_rdidx[RFIDX_W-1] & ~i_ntp};

  // Flush masks the head so no handshake is presented in a cycle that cannot pop.
  assign head_vld = ~empty & ~flush;
  assign hneed    = need_q[hidx];

  assign rdy_c  = ~hneed[0] | cwbck_o_ready;
  assign rdy_qc = ~hneed[1] | qcwbck_o_ready;
  assign rdy_t  = ~hneed[2] | twbck_o_ready;
  assign rdy_e  = ~hneed[3] | ewbck_o_ready;

  assign pop = head_vld & cmt_o_ready & rdy_c & rdy_qc & rdy_t & rdy_e;

  assign cmt_o_valid    = head_vld & rdy_c & rdy_qc & rdy_t & rdy_e;
  assign cwbck_o_valid  = head_vld & hneed[0] & cmt_o_ready & rdy_qc & rdy_t & rdy_e;
  assign qcwbck_o_valid = head_vld & hneed[1] & cmt_o_ready & rdy_c & rdy_t & rdy_e;
  assign twbck_o_valid  = head_vld & hneed[2] & cmt_o_ready & rdy_c & rdy_qc & rdy_e;
  assign ewbck_o_valid  = head_vld & hneed[3] & cmt_o_ready & rdy_c & rdy_qc & rdy_t;

  always_comb begin
    cmt_o_pc       = '0;
    cmt_o_imm      = '0;
    cmt_o_bjp      = 1'b0;
    cmt_o_bjp_prdt = 1'b0;
    cmt_o_bjp_rslv = 1'b0;
    cwbck_o_data   = '0;
    cwbck_o_rdidx  = '0;
    qcwbck_o_data  = '0;
    qcwbck_o_rdidx = '0;
    twbck_o_data   = '0;
    ewbck_o_data   = '0;
    ewbck_o_oprand = '0;
    if (head_vld) begin
      cmt_o_pc       = pc_q[hidx];
      cmt_o_imm      = imm_q[hidx];
      cmt_o_bjp      = bjp_q[hidx];
      cmt_o_bjp_prdt = bjp_q[hidx] & prdt_q[hidx];
      cmt_o_bjp_rslv = bjp_q[hidx] & rslv_q[hidx];
      if (hneed[0]) begin
        cwbck_o_data  = cdata_q[hidx];
        cwbck_o_rdidx = rdidx_q[hidx];
      end
      if (hneed[1]) begin
        qcwbck_o_data  = cdata_q[hidx];
        qcwbck_o_rdidx = rdidx_q[hidx];
      end
      if (hneed[2]) twbck_o_data = tdata_q[hidx];
      if (hneed[3]) begin
        ewbck_o_data   = edata_q[hidx];
        ewbck_o_oprand = oprand_q[hidx];
      end
    end
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PTR_ONE;
      if (pop)  rptr_d = rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[widx]     <= i_pc;
      imm_q[widx]    <= i_imm;
      bjp_q[widx]    <= i_bjp;
      prdt_q[widx]   <= i_bjp_prdt;
      rslv_q[widx]   <= i_bjp_rslv;
      rdidx_q[widx]  <= i_rdidx;
      cdata_q[widx]  <= i_cdata;
      tdata_q[widx]  <= i_tdata;
      edata_q[widx]  <= i_edata;
      oprand_q[widx] <= i_oprand;
      need_q[widx]   <= need_in;
    end
  end

  assign o_occupancy = wptr_q - rptr_q;

endmodule

// File: tb/tb_qpu_exu_alu_wbq.sv
// Directed bench for qpu_exu_alu_wbq: reset, single/multi-destination retire, full/wrap, flush, branch + QC.
module tb_qpu_exu_alu_wbq;

  logic        clk = 1'b0;
  logic        rst, flush, i_valid, i_ready;
  logic [31:0] i_pc, i_imm, i_cdata, i_tdata;
  logic        i_bjp, i_bjp_prdt, i_bjp_rslv, i_qiu, i_ntp, i_rdwen;
  logic [5:0]  i_rdidx;
  logic [15:0] i_edata;
  logic [3:0]  i_oprand;
  logic        cmt_o_valid, cmt_o_ready, cmt_o_bjp, cmt_o_bjp_prdt, cmt_o_bjp_rslv;
  logic [31:0] cmt_o_pc, cmt_o_imm;
  logic        cwbck_o_valid, cwbck_o_ready, qcwbck_o_valid, qcwbck_o_ready;
  logic [31:0] cwbck_o_data, qcwbck_o_data;
  logic [5:0]  cwbck_o_rdidx, qcwbck_o_rdidx;
  logic        twbck_o_valid, twbck_o_ready, ewbck_o_valid, ewbck_o_ready;
  logic [31:0] twbck_o_data;
  logic [15:0] ewbck_o_data;
  logic [3:0]  ewbck_o_oprand;
  logic [2:0]  o_occupancy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  qpu_exu_alu_wbq #(
    .XLEN(32), .TIME_W(32), .EVT_W(16), .EVT_NUM(4), .RFIDX_W(6), .PC_W(32), .DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .i_valid(i_valid), .i_ready(i_ready), .i_pc(i_pc), .i_imm(i_imm),
    .i_bjp(i_bjp), .i_bjp_prdt(i_bjp_prdt), .i_bjp_rslv(i_bjp_rslv),
    .i_qiu(i_qiu), .i_ntp(i_ntp), .i_rdwen(i_rdwen), .i_rdidx(i_rdidx),
    .i_cdata(i_cdata), .i_tdata(i_tdata), .i_edata(i_edata), .i_oprand(i_oprand),
    .cmt_o_valid(cmt_o_valid), .cmt_o_ready(cmt_o_ready), .cmt_o_pc(cmt_o_pc), .cmt_o_imm(cmt_o_imm),
    .cmt_o_bjp(cmt_o_bjp), .cmt_o_bjp_prdt(cmt_o_bjp_prdt), .cmt_o_bjp_rslv(cmt_o_bjp_rslv),
    .cwbck_o_valid(cwbck_o_valid), .cwbck_o_ready(cwbck_o_ready),
    .cwbck_o_data(cwbck_o_data), .cwbck_o_rdidx(cwbck_o_rdidx),
    .qcwbck_o_valid(qcwbck_o_valid), .qcwbck_o_ready(qcwbck_o_ready),
    .qcwbck_o_data(qcwbck_o_data), .qcwbck_o_rdidx(qcwbck_o_rdidx),
    .twbck_o_valid(twbck_o_valid), .twbck_o_ready(twbck_o_ready), .twbck_o_data(twbck_o_data),
    .ewbck_o_valid(ewbck_o_valid), .ewbck_o_ready(ewbck_o_ready),
    .ewbck_o_data(ewbck_o_data), .ewbck_o_oprand(ewbck_o_oprand),
    .o_occupancy(o_occupancy)
  );

  // inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_payload();
    i_valid = 1'b0; i_pc = '0; i_imm = '0; i_bjp = 1'b0; i_bjp_prdt = 1'b0; i_bjp_rslv = 1'b0;
    i_qiu = 1'b0; i_ntp = 1'b0; i_rdwen = 1'b0; i_rdidx = '0; i_cdata = '0; i_tdata = '0;
    i_edata = '0; i_oprand = '0;
  endtask

  task automatic test_reset();
    clear_payload();
    flush = 1'b0; cmt_o_ready = 1'b1; cwbck_o_ready = 1'b1; qcwbck_o_ready = 1'b1;
    twbck_o_ready = 1'b1; ewbck_o_ready = 1'b1;
    rst = 1'b1; i_valid = 1'b1; i_rdwen = 1'b1; i_rdidx = 6'h03; i_cdata = 32'h1111_2222;
    tick(); tick();
    rst = 1'b0; clear_payload();
    @(negedge clk);
    n_chk++; if (o_occupancy !== 3'd0) begin n_fail++; $display("FAIL rst_occ got %0d exp 0", o_occupancy); end
    n_chk++; if ({cmt_o_valid, cwbck_o_valid, qcwbck_o_valid, twbck_o_valid, ewbck_o_valid} !== 5'b0) begin
      n_fail++; $display("FAIL rst_valids got %b exp 00000", {cmt_o_valid, cwbck_o_valid, qcwbck_o_valid, twbck_o_valid, ewbck_o_valid}); end
    n_chk++; if (i_ready !== 1'b1) begin n_fail++; $display("FAIL rst_iready got %b exp 1", i_ready); end
    n_chk++; if ({cmt_o_pc, cwbck_o_data, cwbck_o_rdidx} !== 70'd0) begin
      n_fail++; $display("FAIL rst_data got %h exp 0", {cmt_o_pc, cwbck_o_data, cwbck_o_rdidx}); end
    tick();
  endtask

  task automatic test_classical();
    i_valid = 1'b1; i_rdwen = 1'b1; i_rdidx = 6'h05; i_cdata = 32'hDEAD_BEEF; i_pc = 32'h0000_0100;
    @(negedge clk);
    n_chk++; if (cmt_o_valid !== 1'b0) begin n_fail++; $display("FAIL cls_nobypass got %b exp 0", cmt_o_valid); end
    tick(); clear_payload();
    @(negedge clk);
    n_chk++; if (o_occupancy !== 3'd1) begin n_fail++; $display("FAIL cls_occ1 got %0d exp 1", o_occupancy); end
    n_chk++; if ({cmt_o_valid, cwbck_o_valid} !== 2'b11) begin
      n_fail++; $display("FAIL cls_valid got %b exp 11", {cmt_o_valid, cwbck_o_valid}); end
    n_chk++; if ({qcwbck_o_valid, twbck_o_valid, ewbck_o_valid} !== 3'b000) begin
      n_fail++; $display("FAIL cls_other got %b exp 000", {qcwbck_o_valid, twbck_o_valid, ewbck_o_valid}); end
    n_chk++; if (cwbck_o_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL cls_data got %h exp deadbeef", cwbck_o_data); end
    n_chk++; if (cwbck_o_rdidx !== 6'h05) begin n_fail++; $display("FAIL cls_rdidx got %h exp 05", cwbck_o_rdidx); end
    n_chk++; if (cmt_o_pc !== 32'h0000_0100) begin n_fail++; $display("FAIL cls_pc got %h exp 100", cmt_o_pc); end
    tick();
    @(negedge clk);
    n_chk++; if (o_occupancy !== 3'd0) begin n_fail++; $display("FAIL cls_occ0 got %0d exp 0", o_occupancy); end
    n_chk++; if (cmt_o_valid !== 1'b0) begin n_fail++; $display("FAIL cls_empty_valid got %b exp 0", cmt_o_valid); end
    tick();
  endtask

  task automatic test_multi_dest();
    ewbck_o_ready = 1'b0;
    i_valid = 1'b1; i_ntp = 1'b1; i_tdata = 32'd100; i_edata = 16'h00F1; i_oprand = 4'h3;
    tick(); clear_payload();
    for (int unsigned c = 0; c < 3; c++) begin
      @(negedge clk);
      n_chk++; if ({cmt_o_valid, twbck_o_valid, ewbck_o_valid} !== 3'b001) begin
        n_fail++; $display("FAIL md_stall%0d got %b exp 001", c, {cmt_o_valid, twbck_o_valid, ewbck_o_valid}); end
      n_chk++; if (o_occupancy !== 3'd1) begin n_fail++; $display("FAIL md_hold%0d got %0d exp 1", c, o_occupancy); end
      tick();
    end
    ewbck_o_ready = 1'b1;
    @(negedge clk);
    n_chk++; if ({cmt_o_valid, twbck_o_valid, ewbck_o_valid, cwbck_o_valid, qcwbck_o_valid} !== 5'b11100) begin
      n_fail++; $display("FAIL md_retire got %b exp 11100", {cmt_o_valid, twbck_o_valid, ewbck_o_valid, cwbck_o_valid, qcwbck_o_valid}); end
    n_chk++; if ({twbck_o_data, ewbck_o_data, ewbck_o_oprand} !== {32'd100, 16'h00F1, 4'h3}) begin
      n_fail++; $display("FAIL md_data got %h exp %h", {twbck_o_data, ewbck_o_data, ewbck_o_oprand}, {32'd100, 16'h00F1, 4'h3}); end
    tick();
    @(negedge clk);
    n_chk++; if (o_occupancy !== 3'd0) begin n_fail++; $display("FAIL md_single_pop got %0d exp 0", o_occupancy); end
    tick();
  endtask

  task automatic test_full_wrap();
    logic [31:0] base;
    for (int unsigned r = 0; r < 3; r++) begin
      base = 32'hA000_0000 + (r << 8);
      cmt_o_ready = 1'b0;
      for (int unsigned k = 0; k < 5; k++) begin
        i_valid = 1'b1; i_rdwen = 1'b1; i_rdidx = 6'h01; i_cdata = base + k;
        @(negedge clk);
        n_chk++; if (i_ready !== (k < 4)) begin n_fail++; $display("FAIL fw_iready r%0d k%0d got %b exp %b", r, k, i_ready, (k < 4)); end
        tick();
      end
      i_cdata = base + 32'd5;
      cmt_o_ready = 1'b1;
      @(negedge clk);
      n_chk++; if (o_occupancy !== 3'd4) begin n_fail++; $display("FAIL fw_occ4 r%0d got %0d exp 4", r, o_occupancy); end
      n_chk++; if (i_ready !== 1'b0) begin n_fail++; $display("FAIL fw_full_pop_iready r%0d got %b exp 0", r, i_ready); end
      for (int unsigned k = 0; k < 4; k++) begin
        if (k != 0) @(negedge clk);
        n_chk++; if (!(cwbck_o_valid === 1'b1 && cwbck_o_data === base + k)) begin
          n_fail++; $display("FAIL fw_order r%0d k%0d got v=%b d=%h exp v=1 d=%h", r, k, cwbck_o_valid, cwbck_o_data, base + k); end
        tick();
        clear_payload();
      end
      @(negedge clk);
      n_chk++; if (o_occupancy !== 3'd0) begin n_fail++; $display("FAIL fw_drain r%0d got %0d exp 0", r, o_occupancy); end
      tick();
    end
  endtask

  task automatic test_flush();
    cmt_o_ready = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      i_valid = 1'b1; i_rdwen = 1'b1; i_rdidx = 6'h02; i_cdata = 32'hF000_0000 + k;
      tick();
    end
    flush = 1'b1; i_cdata = 32'hF000_00FF;
    @(negedge clk);
    n_chk++; if (o_occupancy !== 3'd3) begin n_fail++; $display("FAIL fl_pre_occ got %0d exp 3", o_occupancy); end
    n_chk++; if (i_ready !== 1'b0) begin n_fail++; $display("FAIL fl_iready got %b exp 0", i_ready); end
    tick();
    flush = 1'b0; clear_payload(); cmt_o_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (o_occupancy !== 3'd0) begin n_fail++; $display("FAIL fl_occ got %0d exp 0", o_occupancy); end
    n_chk++; if ({cmt_o_valid, cwbck_o_valid} !== 2'b00) begin
      n_fail++; $display("FAIL fl_valids got %b exp 00", {cmt_o_valid, cwbck_o_valid}); end
    tick();
    @(negedge clk);
    n_chk++; if (cmt_o_valid !== 1'b0) begin n_fail++; $display("FAIL fl_lost got %b exp 0", cmt_o_valid); end
    tick();
  endtask

  task automatic test_back_to_back();
    i_valid = 1'b1; i_bjp = 1'b1; i_bjp_prdt = 1'b1; i_bjp_rslv = 1'b0; i_pc = 32'h0000_0200;
    tick();
    clear_payload();
    i_valid = 1'b1; i_rdwen = 1'b1; i_rdidx = 6'h21; i_cdata = 32'h0000_1234;
    @(negedge clk);
    n_chk++; if ({cmt_o_valid, cmt_o_bjp, cmt_o_bjp_prdt, cmt_o_bjp_rslv} !== 4'b1110) begin
      n_fail++; $display("FAIL bq_branch got %b exp 1110", {cmt_o_valid, cmt_o_bjp, cmt_o_bjp_prdt, cmt_o_bjp_rslv}); end
    n_chk++; if ({cwbck_o_valid, qcwbck_o_valid, twbck_o_valid, ewbck_o_valid} !== 4'b0000) begin
      n_fail++; $display("FAIL bq_branch_wb got %b exp 0000", {cwbck_o_valid, qcwbck_o_valid, twbck_o_valid, ewbck_o_valid}); end
    tick();
    clear_payload();
    @(negedge clk);
    n_chk++; if ({qcwbck_o_valid, cwbck_o_valid, cmt_o_bjp, cmt_o_bjp_prdt} !== 4'b1000) begin
      n_fail++; $display("FAIL bq_qc_valid got %b exp 1000", {qcwbck_o_valid, cwbck_o_valid, cmt_o_bjp, cmt_o_bjp_prdt}); end
    n_chk++; if ({qcwbck_o_data, qcwbck_o_rdidx, cwbck_o_rdidx} !== {32'h0000_1234, 6'h21, 6'h00}) begin
      n_fail++; $display("FAIL bq_qc_data got %h exp %h", {qcwbck_o_data, qcwbck_o_rdidx, cwbck_o_rdidx}, {32'h0000_1234, 6'h21, 6'h00}); end
    tick();
    @(negedge clk);
    n_chk++; if (o_occupancy !== 3'd0) begin n_fail++; $display("FAIL bq_drain got %0d exp 0", o_occupancy); end
    tick();
  endtask

  initial begin
    test_reset();
    test_classical();
    test_multi_dest();
    test_full_wrap();
    test_flush();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
